data_memory_manager: RTL and testbench
======================================

DATA_MEMORY_MANAGER -- requirements
Module: data_memory_manager

Interface
REQ-001 Parameter: DEPTH, default 1024, words per region (power of two, ≤ 65536).
REQ-002 Parameter: DATA_W, default 32, data word width.
REQ-003 Port: CLK  input  1  sole clock; all state updates on rising edge.
REQ-004 Port: RST  input  1  reset; synchronous, active-high.
REQ-005 Port: address_i  input  32  word address; bits [31:16] select the region, bits [15:0] are the word index.
REQ-006 Port: data_i  input  DATA_W  write data.
REQ-007 Port: wren_i  input  1  write enable; 1 = write data_i at address_i on this edge.
REQ-008 Port: data_o  output  DATA_W  registered read data.

Function
REQ-009 The address map SHALL have three regions:
- region 0: address_i[31:16] = 0x0000 (base 0x00000).
- region 1: address_i[31:16] = 0x0001 (base 0x10000).
- region 2: address_i[31:16] = 0x0002 (base 0x20000).
- Each region is DEPTH words, word-addressed; the index is address_i[15:0].
REQ-010 An address SHALL be valid only if its region is 0, 1 or 2 and address_i[15:0] < DEPTH; all other addresses are invalid.
REQ-011 On a rising edge with wren_i=1 and a valid address, the selected region SHALL store data_i at the index; the other regions SHALL be unchanged.
REQ-012 Writes to invalid addresses SHALL be ignored, with no aliasing into any region.
REQ-013 Reads are synchronous with 1-cycle latency: data_o after edge N SHALL equal the word at the address sampled at edge N.
REQ-014 A read of an invalid address SHALL drive data_o = 0 after the edge.
REQ-015 data_o SHALL hold its value between edges and SHALL NOT change combinationally with address_i.
REQ-016 Reads SHALL occur on every edge regardless of wren_i.
REQ-017 When wren_i=1, data_o after the edge SHALL show the old contents of the addressed word (read-before-write).
REQ-018 Region selection for data_o SHALL use the registered region code, so the output mux matches the address that was read.
REQ-019 Memory contents SHALL persist indefinitely without refresh.

Reset
REQ-020 While RST=1 at a rising edge, data_o SHALL become 0 and the registered region/valid state SHALL clear; writes are suppressed that cycle.
REQ-021 Memory array contents SHALL NOT be cleared by reset; their power-up value is undefined.
REQ-022 On the first edge after RST falls, normal read/write operation SHALL resume.

Structure
REQ-023 A package dmm_pkg SHALL hold:
- region base constants (0x00000, 0x10000, 0x20000);
- region-count constant (3);
- a region enum {REG0, REG1, REG2, REG_NONE}.
REQ-024 A single-port synchronous RAM sub-module dmm_ram (DEPTH x DATA_W, registered read, read-before-write, per-instance write enable) SHALL be instantiated three times, one per region.
REQ-025 The top level SHALL contain only address decode, write-enable gating, the registered region/valid state, and the output mux.

Verification
REQ-026 Region 0 write/read: write data = address for 0x00000..0x0000E, then read each address holding it 2 edges -> data_o equals the address value.
REQ-027 Region isolation: write 0x10000..0x1000E and 0x20000..0x2000E with data = address, then re-read 0x00000..0x0000E -> region 0 values unchanged; each region returns its own values.
REQ-028 Latency: write 0xA5A5A5A5 to 0x10005, then present 0x10005 with wren_i=0 -> data_o = 0xA5A5A5A5 exactly one edge later, and the prior value before that edge.
REQ-029 Invalid addresses:
- write 0xDEADBEEF to 0x30000 and to 0x00000+DEPTH;
- read both -> data_o = 0;
- read 0x00000 -> unchanged.
REQ-030 Read-before-write: 0x20003 holds 0x11; write 0x22 to it -> data_o = 0x11 after that edge and 0x22 on the next read.
REQ-031 Reset: assert RST for one edge mid-sequence -> data_o = 0; a following read of 0x00004 returns the previously written 0x4.

Source files
------------

// File: rtl/dmm_pkg.sv
// ---------------------------------------------------------------------------
// dmm_pkg
//   Shared definitions for the data memory manager:
//   - region base addresses and region count
//   - region_t enum used for the address decode and the registered output mux
//   - decode_region(): maps address bits [31:16] to a region code
// ---------------------------------------------------------------------------
package dmm_pkg;

  localparam logic [31:0] REG0_BASE   = 32'h0000_0000;
  localparam logic [31:0] REG1_BASE   = 32'h0001_0000;
  localparam logic [31:0] REG2_BASE   = 32'h0002_0000;
  localparam int          NUM_REGIONS = 3;

  typedef enum logic [1:0] {
    REG0     = 2'd0,
    REG1     = 2'd1,
    REG2     = 2'd2,
    REG_NONE = 2'd3
  } region_t;

  // The full upper half-word is compared so that e.g. 0x0003 or 0x0102
  // never alias onto one of the three real regions.
  function automatic region_t decode_region(input logic [15:0] region_bits);
    region_t r;
    r = REG_NONE;
    if (region_bits == REG0_BASE[31:16]) r = REG0;
    else if (region_bits == REG1_BASE[31:16]) r = REG1;
    else if (region_bits == REG2_BASE[31:16]) r = REG2;
    return r;
  endfunction

endpackage

// File: rtl/dmm_ram.sv
// ---------------------------------------------------------------------------
// dmm_ram
//   Single-port synchronous RAM, DEPTH x DATA_W, one-cycle registered read,
//   read-before-write. Contents are never reset.
//
// Ports
//   clk    : clock, all updates on the rising edge
//   we     : write enable for this instance
//   addr   : word index
//   wdata  : write data
//   rdata  : registered read data (old contents when written the same edge)
// ---------------------------------------------------------------------------
module dmm_ram #(
  parameter int DEPTH  = 1024,
  parameter int DATA_W = 32,
  localparam int AW    = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
  input  logic              clk,
  input  logic              we,
  input  logic [AW-1:0]     addr,
  input  logic [DATA_W-1:0] wdata,
  output logic [DATA_W-1:0] rdata
);

  logic [DATA_W-1:0] mem [DEPTH];

  // The read samples the array before the write lands, giving
  // read-before-write behaviour on a same-address access.
  always_ff @(posedge clk) begin
    if (we) begin
      mem[addr] <= wdata;
    end
    rdata <= mem[addr];
  end

endmodule

// File: rtl/data_memory_manager.sv
// ---------------------------------------------------------------------------
// data_memory_manager
//   Three-region word-addressed data memory. address_i[31:16] selects the
//   region (0, 1 or 2), address_i[15:0] is the word index within a DEPTH-word
//   region. Invalid addresses ignore writes and read back as zero.
//
// Ports
//   CLK       : clock, all state updates on the rising edge
//   RST       : synchronous active-high reset (clears output state only)
//   address_i : 32-bit word address
//   data_i    : write data
//   wren_i    : write enable
//   data_o    : read data, one edge after the address is presented
// ---------------------------------------------------------------------------
module data_memory_manager
  import dmm_pkg::*;
#(
  parameter int DEPTH  = 1024,
  parameter int DATA_W = 32
) (
  input  logic              CLK,
  input  logic              RST,
  input  logic [31:0]       address_i,
  input  logic [DATA_W-1:0] data_i,
  input  logic              wren_i,
  output logic [DATA_W-1:0] data_o
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  region_t           region;
  logic              index_ok;
  logic              addr_valid;
  logic [AW-1:0]     ram_addr;
  logic [NUM_REGIONS-1:0] ram_we;
  logic [DATA_W-1:0] ram_rdata [NUM_REGIONS];

  region_t           region_q;
  logic              valid_q;

  // Address decode: the index bound is checked on the full 16-bit index so
  // that indices at or above DEPTH are rejected instead of wrapping.
  always_comb begin
    region     = decode_region(address_i[31:16]);
    index_ok   = ({16'b0, address_i[15:0]} < 32'(DEPTH));
    addr_valid = (region != REG_NONE) && index_ok;
    ram_addr   = address_i[AW-1:0];
  end

  // Write-enable gating: only the addressed region sees a write, and only
  // for a valid address outside of reset.
  always_comb begin
    ram_we = '0;
    if (wren_i && addr_valid && !RST) begin
      case (region)
        REG0:    ram_we[0] = 1'b1;
        REG1:    ram_we[1] = 1'b1;
        REG2:    ram_we[2] = 1'b1;
        default: ram_we    = '0;
      endcase
    end
  end

  for (genvar g = 0; g < NUM_REGIONS; g++) begin : g_region
    dmm_ram #(
      .DEPTH  (DEPTH),
      .DATA_W (DATA_W)
    ) u_ram (
      .clk   (CLK),
      .we    (ram_we[g]),
      .addr  (ram_addr),
      .wdata (data_i),
      .rdata (ram_rdata[g])
    );
  end

  // The region code and validity travel alongside the RAM read so the
  // output mux selects the region that was addressed on the read edge.
  always_ff @(posedge CLK) begin
    if (RST) begin
      region_q <= REG_NONE;
      valid_q  <= 1'b0;
    end else begin
      region_q <= region;
      valid_q  <= addr_valid;
    end
  end

  // Output mux driven only by registered state, so data_o is stable between
  // edges and zero after an invalid read or a reset edge.
  always_comb begin
    data_o = '0;
    if (valid_q) begin
      case (region_q)
        REG0:    data_o = ram_rdata[0];
        REG1:    data_o = ram_rdata[1];
        REG2:    data_o = ram_rdata[2];
        default: data_o = '0;
      endcase
    end
  end

endmodule

// File: tb/tb_data_memory_manager.sv
// ---------------------------------------------------------------------------
// tb_data_memory_manager
//   Directed scoreboard bench for data_memory_manager. The driver pushes one
//   expected entry per clock edge; the monitor pops one entry per edge and
//   compares data_o shortly after the edge and again after the next falling
//   edge (when the address has already moved on).
// ---------------------------------------------------------------------------
module tb_data_memory_manager;

  localparam int DEPTH  = 64;
  localparam int DATA_W = 32;

  typedef struct {
    logic        chk;
    logic [31:0] exp;
    string       tag;
  } exp_t;

  logic              CLK;
  logic              RST;
  logic [31:0]       address_i;
  logic [DATA_W-1:0] data_i;
  logic              wren_i;
  logic [DATA_W-1:0] data_o;

  exp_t sb [$];
  int   vectors;
  int   miscompares;

  data_memory_manager #(
    .DEPTH  (DEPTH),
    .DATA_W (DATA_W)
  ) dut (
    .CLK       (CLK),
    .RST       (RST),
    .address_i (address_i),
    .data_i    (data_i),
    .wren_i    (wren_i),
    .data_o    (data_o)
  );

  initial begin
    CLK = 1'b0;
    forever #5 CLK = ~CLK;
  end

  // Drive one edge worth of inputs and queue what data_o must show after it.
  task automatic applyStimulus(input logic rst, input logic [31:0] addr,
                               input logic [31:0] data, input logic wren,
                               input logic chk, input logic [31:0] exp,
                               input string tag);
    exp_t e;
    @(negedge CLK);
    RST       = rst;
    address_i = addr;
    data_i    = data;
    wren_i    = wren;
    e.chk = chk;
    e.exp = exp;
    e.tag = tag;
    sb.push_back(e);
  endtask

  // Compare one scoreboard entry just after its edge, then confirm data_o
  // holds across the following input change.
  task automatic checkOutput(input exp_t e);
    logic [31:0] seen;
    if (e.chk) begin
      vectors++;
      seen = data_o;
      if (seen !== e.exp) begin
        miscompares++;
        $display("[TB] FAIL %s: data_o=%h expected=%h", e.tag, seen, e.exp);
      end
      @(negedge CLK);
      #1;
      vectors++;
      if (data_o !== e.exp) begin
        miscompares++;
        $display("[TB] FAIL %s_hold: data_o=%h expected=%h", e.tag, data_o, e.exp);
      end
    end
  endtask

  initial begin
    exp_t e;
    forever begin
      @(posedge CLK);
      #1;
      if (sb.size() > 0) begin
        e = sb.pop_front();
        checkOutput(e);
      end
    end
  end

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation time exceeded, %0d entries pending", sb.size());
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    logic [31:0] a;
    vectors     = 0;
    miscompares = 0;
    RST         = 1'b1;
    address_i   = '0;
    data_i      = '0;
    wren_i      = 1'b0;

    // Reset state
    applyStimulus(1'b1, 32'h0, 32'h0, 1'b0, 1'b1, 32'h0, "reset0");
    applyStimulus(1'b1, 32'h0, 32'h0, 1'b0, 1'b1, 32'h0, "reset1");

    // Region 0 fill with data = address
    for (int i = 0; i < 15; i++) begin
      a = 32'h0000_0000 + i;
      applyStimulus(1'b0, a, a, 1'b1, 1'b0, 32'h0, "r0_wr");
    end
    // Region 0 read-back, each address held for two edges
    for (int i = 0; i < 15; i++) begin
      a = 32'h0000_0000 + i;
      applyStimulus(1'b0, a, 32'h0, 1'b0, 1'b1, a, "r0_rd_a");
      applyStimulus(1'b0, a, 32'h0, 1'b0, 1'b1, a, "r0_rd_b");
    end

    // Regions 1 and 2 fill
    for (int i = 0; i < 15; i++) begin
      a = 32'h0001_0000 + i;
      applyStimulus(1'b0, a, a, 1'b1, 1'b0, 32'h0, "r1_wr");
    end
    for (int i = 0; i < 15; i++) begin
      a = 32'h0002_0000 + i;
      applyStimulus(1'b0, a, a, 1'b1, 1'b0, 32'h0, "r2_wr");
    end

    // Isolation: every region returns its own values
    for (int i = 0; i < 15; i++) begin
      a = 32'h0000_0000 + i;
      applyStimulus(1'b0, a, 32'h0, 1'b0, 1'b1, a, "iso_r0");
    end
    for (int i = 0; i < 15; i++) begin
      a = 32'h0001_0000 + i;
      applyStimulus(1'b0, a, 32'h0, 1'b0, 1'b1, a, "iso_r1");
    end
    for (int i = 0; i < 15; i++) begin
      a = 32'h0002_0000 + i;
      applyStimulus(1'b0, a, 32'h0, 1'b0, 1'b1, a, "iso_r2");
    end

    // Latency: the write edge shows the old word, the next edge the new one
    applyStimulus(1'b0, 32'h0001_0005, 32'hA5A5_A5A5, 1'b1, 1'b1, 32'h0001_0005, "lat_old");
    applyStimulus(1'b0, 32'h0001_0005, 32'h0, 1'b0, 1'b1, 32'hA5A5_A5A5, "lat_new");
    applyStimulus(1'b0, 32'h0000_0005, 32'h0, 1'b0, 1'b1, 32'h0000_0005, "lat_r0");

    // Invalid addresses: writes ignored, reads return zero, no aliasing
    applyStimulus(1'b0, 32'h0003_0000, 32'hDEAD_BEEF, 1'b1, 1'b1, 32'h0, "inv_wr_reg");
    applyStimulus(1'b0, 32'h0000_0000 + DEPTH, 32'hDEAD_BEEF, 1'b1, 1'b1, 32'h0, "inv_wr_idx");
    applyStimulus(1'b0, 32'h0003_0000, 32'h0, 1'b0, 1'b1, 32'h0, "inv_rd_reg");
    applyStimulus(1'b0, 32'h0000_0000 + DEPTH, 32'h0, 1'b0, 1'b1, 32'h0, "inv_rd_idx");
    applyStimulus(1'b0, 32'h0000_0000, 32'h0, 1'b0, 1'b1, 32'h0, "inv_r0_keep");
    applyStimulus(1'b0, 32'h0001_0000, 32'h0, 1'b0, 1'b1, 32'h0001_0000, "inv_r1_keep");
    applyStimulus(1'b0, 32'h0100_0002, 32'hDEAD_BEEF, 1'b1, 1'b1, 32'h0, "inv_hi_reg");
    applyStimulus(1'b0, 32'h0002_0002, 32'h0, 1'b0, 1'b1, 32'h0002_0002, "inv_r2_keep");

    // Last valid index in a region
    applyStimulus(1'b0, 32'h0002_0000 + DEPTH - 1, 32'h1234_5678, 1'b1, 1'b0, 32'h0, "top_wr");
    applyStimulus(1'b0, 32'h0002_0000 + DEPTH - 1, 32'h0, 1'b0, 1'b1, 32'h1234_5678, "top_rd");

    // Read-before-write on 0x20003
    applyStimulus(1'b0, 32'h0002_0003, 32'h11, 1'b1, 1'b1, 32'h0002_0003, "rbw_prep");
    applyStimulus(1'b0, 32'h0002_0003, 32'h22, 1'b1, 1'b1, 32'h11, "rbw_old");
    applyStimulus(1'b0, 32'h0002_0003, 32'h0, 1'b0, 1'b1, 32'h22, "rbw_new");

    // Mid-sequence reset: output clears, a write during reset is dropped,
    // memory keeps its contents
    applyStimulus(1'b0, 32'h0000_0004, 32'h0, 1'b0, 1'b1, 32'h4, "pre_rst");
    applyStimulus(1'b1, 32'h0000_0004, 32'hFFFF_FFFF, 1'b1, 1'b1, 32'h0, "mid_rst");
    applyStimulus(1'b0, 32'h0000_0004, 32'h0, 1'b0, 1'b1, 32'h4, "post_rst");
    applyStimulus(1'b0, 32'h0001_0005, 32'h0, 1'b0, 1'b1, 32'hA5A5_A5A5, "post_rst_r1");

    // Drain the scoreboard within a bounded number of cycles
    for (int k = 0; k < 10 && sb.size() > 0; k++) begin
      @(negedge CLK);
    end
    if (sb.size() > 0) begin
      miscompares++;
      $display("[TB] FAIL drain: pending=%0d expected=0", sb.size());
    end
    repeat (2) @(negedge CLK);
    #2;

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
